// File: rtl/rx_bit_timer.sv
// rx_bit_timer: UART RX bit-centre strobe and frame-done generator.
// Define RX_TIMER_BITIDX_EN to expose the bit_index port.
module rx_bit_timer #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_timer,
  input  logic [CNT_W-1:0] bit_period,
  input  logic [3:0]       data_size,
`ifdef RX_TIMER_BITIDX_EN
  output logic [3:0]       bit_index,
`endif
  output logic             shift_strobe,
  output logic             packet_done,
  output logic             timer_active
);

  typedef enum logic [2:0] {
    IDLE,
    OFFSET,
    BIT,
    DONE,
    HOLD
  } state_t;

  localparam logic [CNT_W:0]   ONE  = 1;
  localparam logic [CNT_W-1:0] PMIN = 4;

  state_t           state, state_n;
  logic [CNT_W-1:0] p_q, p_n, p_clamp;
  logic [3:0]       n_q, n_n, n_clamp;
  logic [CNT_W:0]   cnt, cnt_n;
  logic [CNT_W:0]   offset;
  logic [3:0]       bits, bits_n;
  logic             strobe_q, strobe_n;
  logic             done_q, done_n;
  logic             active_q, active_n;

  assign p_clamp = (bit_period < PMIN) ? PMIN : bit_period;
  assign n_clamp = (data_size >= 4'd5 && data_size <= 4'd8)
                 ? data_size : 4'd8;

  // 1.5 bit periods from the start edge lands mid first data bit
  assign offset = {1'b0, p_q} + {2'b00, p_q[CNT_W-1:1]};

  always_comb begin
    state_n  = state;
    p_n      = p_q;
    n_n      = n_q;
    cnt_n    = cnt;
    bits_n   = bits;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    active_n = (state == OFFSET) || (state == BIT);
    unique case (state)
      IDLE: begin
        bits_n = 4'd0;
        if (enable_timer) begin
          p_n     = p_clamp;
          n_n     = n_clamp;
          cnt_n   = ONE;
          state_n = OFFSET;
        end
      end
      OFFSET: begin
        if (!enable_timer) begin
          state_n = IDLE;
          bits_n  = 4'd0;
        end else if (cnt == offset) begin
          strobe_n = 1'b1;
          bits_n   = 4'd1;
          cnt_n    = ONE;
          state_n  = BIT;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      BIT: begin
        if (!enable_timer) begin
          state_n = IDLE;
          bits_n  = 4'd0;
        end else if (cnt == {1'b0, p_q}) begin
          strobe_n = 1'b1;
          bits_n   = bits + 4'd1;
          cnt_n    = ONE;
          if (bits == n_q) state_n = DONE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        if (!enable_timer) begin
          state_n = IDLE;
          bits_n  = 4'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      p_q      <= '0;
      n_q      <= '0;
      cnt      <= '0;
      bits     <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_n;
      p_q      <= p_n;
      n_q      <= n_n;
      cnt      <= cnt_n;
      bits     <= bits_n;
      strobe_q <= strobe_n;
      done_q   <= done_n;
      active_q <= active_n;
    end
  end

  assign shift_strobe = strobe_q;
  assign packet_done  = done_q;
  assign timer_active = active_q;
`ifdef RX_TIMER_BITIDX_EN
  assign bit_index    = bits;
`endif

endmodule
